// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX blocks: FSM state encoding and parity mode constants.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: one-cycle o_tick every DIV clocks, restartable with i_clr. Shared by TX and RX.
module uart_baud_gen #(
   parameter int DIV = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;

   assign o_tick = (cnt_q == CW'(DIV - 1));

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (i_clr || o_tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter, one word per valid/ready handshake, zero-gap back-to-back frames.
// Parity bit and PARITY state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int FREQ      = 50_000_000,
   parameter int RATE      = 2_000_000,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_vld,
   output logic                 o_rdy,
   output logic                 o_tx,
   output logic                 o_busy
);

   localparam int DIV = FREQ / RATE;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_ACT = (PARITY != PAR_NONE);
   localparam bit PAR_INV = (PARITY == PAR_ODD);
`endif

   if (DIV < 2) begin : g_div_chk
      $error("uart_tx_frame: FREQ/RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
      $error("uart_tx_frame: DATA_BITS must be in 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_par_chk
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end

   tx_state_e            state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [3:0]           bitcnt_q;
   logic                 stopcnt_q;
   logic                 tx_q;
   logic                 par_q;
   logic                 tick;
   logic                 last_stop;
   logic                 rdy;
   logic                 hs;

   // Accepting in the final stop-bit cycle is what lets frames run with no idle gap.
   assign last_stop = (state_q == ST_STOP) && tick && (stopcnt_q == 1'(STOP_BITS - 1));
   assign rdy       = (state_q == ST_IDLE) || last_stop;
   assign hs        = i_vld && rdy;

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (hs || (state_q == ST_IDLE)),
      .o_tick (tick)
   );

   // NOTE: rst_n is asynchronous, so the line returns high the moment reset asserts, mid-frame or not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bitcnt_q  <= '0;
         stopcnt_q <= 1'b0;
         tx_q      <= 1'b1;
         par_q     <= 1'b0;
      end else if (hs) begin
         state_q   <= ST_START;
         shift_q   <= i_data;
         bitcnt_q  <= '0;
         stopcnt_q <= 1'b0;
         tx_q      <= 1'b0;
         par_q     <= 1'b0;
      end else if (tick) begin
         case (state_q)
            ST_START: begin
               state_q <= ST_DATA;
               tx_q    <= shift_q[0];
               par_q   <= par_q ^ shift_q[0];
               shift_q <= shift_q >> 1;
            end
            ST_DATA: begin
               if (bitcnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  if (PAR_ACT) begin
                     state_q <= ST_PARITY;
                     tx_q    <= par_q ^ PAR_INV;
                  end else begin
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
                  end
`else
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
`endif
               end else begin
                  bitcnt_q <= bitcnt_q + 4'd1;
                  tx_q     <= shift_q[0];
                  par_q    <= par_q ^ shift_q[0];
                  shift_q  <= shift_q >> 1;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               state_q <= ST_STOP;
               tx_q    <= 1'b1;
            end
`endif
            ST_STOP: begin
               if (stopcnt_q == 1'(STOP_BITS - 1)) begin
                  state_q <= ST_IDLE;
               end else begin
                  stopcnt_q <= 1'b1;
               end
               tx_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign o_rdy  = rdy;
   assign o_tx   = tx_q;
   assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1 at DIV=25 plus two 7-bit/2-stop units (even and odd parity).
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [2:0]      vld_r = '0;
   logic [2:0][8:0] data_r = '0;
   logic [2:0]      tx_w, rdy_w, busy_w;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uart_tx_frame #(.FREQ(50_000_000), .RATE(2_000_000), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .i_data(data_r[0][7:0]), .i_vld(vld_r[0]),
      .o_rdy(rdy_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]));

   uart_tx_frame #(.FREQ(50_000_000), .RATE(5_000_000), .DATA_BITS(7), .STOP_BITS(2), .PARITY(1)) u_even (
      .clk(clk), .rst_n(rst_n), .i_data(data_r[1][6:0]), .i_vld(vld_r[1]),
      .o_rdy(rdy_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]));

   uart_tx_frame #(.FREQ(50_000_000), .RATE(5_000_000), .DATA_BITS(7), .STOP_BITS(2), .PARITY(2)) u_odd (
      .clk(clk), .rst_n(rst_n), .i_data(data_r[2][6:0]), .i_vld(vld_r[2]),
      .o_rdy(rdy_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]));

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   // Sends w on unit u and checks o_tx per bit window, o_busy and o_rdy per cycle.
   // Returns in the final stop-bit cycle (T+L); with hold the next handshake is on the coming edge.
   task automatic frame(input int u, input logic [8:0] w, input int div, input int nb, input int ns,
                        input int pm, input bit hold, input bit scramble, input string name);
      logic exp_bits[16];
      logic p, seen, busy_bad, rdy_bad, rdy_exp;
      int   total;
      bit   bad;
      p = 1'b0;
      for (int i = 0; i < nb; i++) p ^= w[i];
      total = 1 + nb + ((pm != 0) ? 1 : 0) + ns;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < nb; i++) exp_bits[1 + i] = w[i];
      if (pm != 0) exp_bits[1 + nb] = (pm == 2) ? ~p : p;
      for (int i = total - ns; i < total; i++) exp_bits[i] = 1'b1;
      data_r[u] = w;
      vld_r[u]  = 1'b1;
      tick_clk();
      if (!hold) vld_r[u] = 1'b0;
      busy_bad = 1'b0;
      rdy_bad  = 1'b0;
      for (int k = 0; k < total; k++) begin
         bad  = 1'b0;
         seen = exp_bits[k];
         for (int c = 0; c < div; c++) begin
            if (scramble) data_r[u] = 9'($urandom);
            if (tx_w[u] !== exp_bits[k]) begin
               bad  = 1'b1;
               seen = tx_w[u];
            end
            if (busy_w[u] !== 1'b1) busy_bad = 1'b1;
            rdy_exp = (k == total - 1) && (c == div - 1);
            if (rdy_w[u] !== rdy_exp) rdy_bad = 1'b1;
            if (!rdy_exp) tick_clk();
         end
         vectors++;
         if (bad) begin
            miscompares++;
            $display("FAIL %s bit %0d: o_tx showed %b, expected %b for all %0d cycles", name, k, seen, exp_bits[k], div);
         end
      end
      vectors++;
      if (busy_bad) begin
         miscompares++;
         $display("FAIL %s busy: o_busy dropped during frame, expected 1 throughout", name);
      end
      vectors++;
      if (rdy_bad) begin
         miscompares++;
         $display("FAIL %s rdy: o_rdy wrong during frame, expected high only in last cycle", name);
      end
   endtask

   task automatic check_idle(input int u, input string name);
      tick_clk();
      vectors++;
      if ({tx_w[u], rdy_w[u], busy_w[u]} !== 3'b110) begin
         miscompares++;
         $display("FAIL %s idle: tx/rdy/busy = %b%b%b, expected 110", name, tx_w[u], rdy_w[u], busy_w[u]);
      end
   endtask

   task automatic test_reset();
      bit bad;
      rst_n = 1'b0;
      bad   = 1'b0;
      repeat (5) begin
         tick_clk();
         if (tx_w !== 3'b111 || rdy_w !== 3'b111 || busy_w !== 3'b000) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL reset_hold: tx=%b rdy=%b busy=%b, expected 111/111/000", tx_w, rdy_w, busy_w);
      end
      rst_n = 1'b1;
      bad   = 1'b0;
      repeat (60) begin
         tick_clk();
         if (tx_w !== 3'b111 || rdy_w !== 3'b111 || busy_w !== 3'b000) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL reset_idle: tx=%b rdy=%b busy=%b, expected 111/111/000", tx_w, rdy_w, busy_w);
      end
   endtask

   task automatic test_8n1();
      frame(0, 9'h0A5, 25, 8, 1, 0, 1'b0, 1'b0, "8n1_a5");
      check_idle(0, "8n1_a5");
   endtask

   task automatic test_back_to_back();
      frame(0, 9'h000, 25, 8, 1, 0, 1'b1, 1'b0, "b2b_00");
      frame(0, 9'h0FF, 25, 8, 1, 0, 1'b0, 1'b0, "b2b_ff");
      check_idle(0, "b2b_ff");
   endtask

   task automatic test_parity();
      frame(1, 9'h055, 10, 7, 2, PAR_ON ? 1 : 0, 1'b0, 1'b0, "par_even_55");
      check_idle(1, "par_even_55");
      frame(2, 9'h055, 10, 7, 2, PAR_ON ? 2 : 0, 1'b0, 1'b0, "par_odd_55");
      check_idle(2, "par_odd_55");
   endtask

   task automatic test_reset_mid_frame();
      data_r[0] = 9'h0A5;
      vld_r[0]  = 1'b1;
      tick_clk();
      vld_r[0]  = 1'b0;
      repeat (4 * 25 + 5) tick_clk();
      vectors++;
      if (tx_w[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid pre: o_tx in data bit 3 of 0xA5 is %b, expected 0", tx_w[0]);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({tx_w[0], rdy_w[0], busy_w[0]} !== 3'b110) begin
         miscompares++;
         $display("FAIL rst_mid async: tx/rdy/busy = %b%b%b, expected 110", tx_w[0], rdy_w[0], busy_w[0]);
      end
      repeat (3) tick_clk();
      rst_n = 1'b1;
      tick_clk();
      frame(0, 9'h03C, 25, 8, 1, 0, 1'b0, 1'b0, "rst_mid_3c");
      check_idle(0, "rst_mid_3c");
   endtask

   task automatic test_data_toggle();
      frame(0, 9'h096, 25, 8, 1, 0, 1'b0, 1'b1, "toggle_96");
      check_idle(0, "toggle_96");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_8n1();
      test_back_to_back();
      test_parity();
      test_reset_mid_frame();
      test_data_toggle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
